dfi_phy_datapath: RTL and testbench

// - PHY-side (DFI slave) data responder: the far end of the controller datapath's DFI data bus.
// - Captures write data tphy_wrlat cycles after dfi_wrdata_en and stores it in a loopback FIFO.
// - Returns stored data tphy_rdlat cycles after dfi_rddata_en, with dfi_rddata_valid.
// - Used as the PHY/memory stand-in for controller bring-up and for loopback BIST.

---
 rtl/dfi_phy_datapath_pkg.sv | 25 ++
 rtl/dfi_phy_datapath_if.sv | 34 +++
 rtl/dfi_phy_datapath_lat_pipe.sv | 45 ++++
 rtl/dfi_phy_datapath.sv | 140 ++++++++++++++
 tb/tb_dfi_phy_datapath.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dfi_phy_datapath_pkg.sv
// -----------------------------------------------------------------------------
// dfi_phy_datapath_pkg
// Shared definitions for the PHY-side DFI data responder.
//   - default bus geometry and latencies (the top-level parameters start from these)
//   - lat_t   : 4-bit latency type for the write/read PHY latencies
//   - f_byte_keep : expands one mask bit into the AND pattern for its byte
// -----------------------------------------------------------------------------
package dfi_phy_datapath_pkg;

    localparam int C_DEF_FREQ_RATIO = 4;
    localparam int C_DEF_DATA_WIDTH = 32;
    localparam int C_DEF_ADDR_WIDTH = 6;
    localparam int C_CNT_WIDTH      = 16;

    typedef logic [3:0] lat_t;

    localparam lat_t C_DEF_TPHY_WRLAT = 4'd2;
    localparam lat_t C_DEF_TPHY_RDLAT = 4'd3;

    // A set mask bit means the byte is discarded: it is stored as 8'h00.
    function automatic logic [7:0] f_byte_keep(input logic i_masked);
        return i_masked ? 8'h00 : 8'hFF;
    endfunction

endpackage

// File: rtl/dfi_phy_datapath_if.sv
// -----------------------------------------------------------------------------
// dfi_phy_datapath_if
// DFI data bus between a memory controller (master) and the PHY (slave).
//   dfi_wrdata_en    MC->PHY  R bits   per-phase write-data enable
//   dfi_wrdata       MC->PHY  W bits   write data
//   dfi_wrdata_mask  MC->PHY  W/8 bits per-byte mask, 1 = masked
//   dfi_rddata_en    MC->PHY  R bits   per-phase read-data enable
//   dfi_rddata       PHY->MC  W bits   read data
//   dfi_rddata_valid PHY->MC  R bits   per-phase read valid
// (R = C_DFI_FREQ_RATIO, W = R * C_DFI_DATA_WIDTH)
// -----------------------------------------------------------------------------
interface dfi_phy_datapath_if #(
    parameter int C_DFI_FREQ_RATIO = dfi_phy_datapath_pkg::C_DEF_FREQ_RATIO,
    parameter int C_DFI_DATA_WIDTH = dfi_phy_datapath_pkg::C_DEF_DATA_WIDTH
);
    localparam int W = C_DFI_FREQ_RATIO * C_DFI_DATA_WIDTH;

    logic [C_DFI_FREQ_RATIO-1:0] dfi_wrdata_en;
    logic [W-1:0]                dfi_wrdata;
    logic [W/8-1:0]              dfi_wrdata_mask;
    logic [C_DFI_FREQ_RATIO-1:0] dfi_rddata_en;
    logic [W-1:0]                dfi_rddata;
    logic [C_DFI_FREQ_RATIO-1:0] dfi_rddata_valid;

    modport master (
        output dfi_wrdata_en, dfi_wrdata, dfi_wrdata_mask, dfi_rddata_en,
        input  dfi_rddata, dfi_rddata_valid
    );

    modport slave (
        input  dfi_wrdata_en, dfi_wrdata, dfi_wrdata_mask, dfi_rddata_en,
        output dfi_rddata, dfi_rddata_valid
    );
endinterface

// File: rtl/dfi_phy_datapath_lat_pipe.sv
// -----------------------------------------------------------------------------
// dfi_lat_pipe
// 1-bit delay line of DEPTH register stages with synchronous reset.
// DEPTH = 0 is a combinational pass-through.
//   clk   in  clock
//   srst  in  synchronous reset, active-high; clears every stage
//   i_d   in  bit to delay
//   o_q   out i_d delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module dfi_lat_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic i_d,
    output logic o_q
);
    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_shift
            logic [DEPTH-1:0] r_stage;
            logic [DEPTH-1:0] w_stage_in;

            // Each stage loads from the one before it; stage 0 loads the input.
            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_link
                if (gi == 0) begin : g_head
                    assign w_stage_in[gi] = i_d;
                end else begin : g_body
                    assign w_stage_in[gi] = r_stage[gi-1];
                end
            end

            always_ff @(posedge clk) begin
                if (srst) begin
                    r_stage <= '0;
                end else begin
                    r_stage <= w_stage_in;
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/dfi_phy_datapath.sv
// -----------------------------------------------------------------------------
// dfi_phy_datapath
// PHY-side DFI data responder: captures write beats C_TPHY_WRLAT cycles after
// dfi_wrdata_en into a loopback FIFO and returns them C_TPHY_RDLAT cycles after
// dfi_rddata_en with dfi_rddata_valid.
//   core_clk       in   single clock
//   core_rst       in   synchronous reset, active-high
//   dfi            slave DFI data bus (enables, write data/mask, read data/valid)
//   wr_count       out  beats captured (wraps at 2**16)
//   rd_count       out  beats returned (wraps at 2**16)
//   err_overflow   out  sticky: capture attempted while FIFO full
//   err_underflow  out  sticky: return due while FIFO empty
//   err_phase      out  sticky: enable with a partial phase pattern
// -----------------------------------------------------------------------------
module dfi_phy_datapath
    import dfi_phy_datapath_pkg::*;
#(
    parameter int   C_DFI_FREQ_RATIO = C_DEF_FREQ_RATIO,
    parameter int   C_DFI_DATA_WIDTH = C_DEF_DATA_WIDTH,
    parameter int   C_ADDR_WIDTH     = C_DEF_ADDR_WIDTH,
    parameter lat_t C_TPHY_WRLAT     = C_DEF_TPHY_WRLAT,
    parameter lat_t C_TPHY_RDLAT     = C_DEF_TPHY_RDLAT
) (
    input  logic                   core_clk,
    input  logic                   core_rst,
    dfi_phy_datapath_if.slave      dfi,
    output logic [C_CNT_WIDTH-1:0] wr_count,
    output logic [C_CNT_WIDTH-1:0] rd_count,
    output logic                   err_overflow,
    output logic                   err_underflow,
    output logic                   err_phase
);
    localparam int W     = C_DFI_FREQ_RATIO * C_DFI_DATA_WIDTH;
    localparam int NB    = W / 8;
    localparam int DEPTH = 2 ** C_ADDR_WIDTH;

    // ---------------- enable decode ----------------
    logic w_wr_beat, w_rd_beat, w_phase_bad;
    assign w_wr_beat   = |dfi.dfi_wrdata_en;
    assign w_rd_beat   = |dfi.dfi_rddata_en;
    assign w_phase_bad = (w_wr_beat && !(&dfi.dfi_wrdata_en)) ||
                         (w_rd_beat && !(&dfi.dfi_rddata_en));

    // ---------------- latency pipes ----------------
    // The read pipe is one stage short: the registered FIFO read / valid
    // register supplies the last cycle of read latency.
    logic w_push_req, w_rd_due;

    dfi_lat_pipe #(.DEPTH(int'(C_TPHY_WRLAT))) u_wr_pipe (
        .clk  (core_clk),
        .srst (core_rst),
        .i_d  (w_wr_beat),
        .o_q  (w_push_req)
    );

    dfi_lat_pipe #(.DEPTH(int'(C_TPHY_RDLAT) - 1)) u_rd_pipe (
        .clk  (core_clk),
        .srst (core_rst),
        .i_d  (w_rd_beat),
        .o_q  (w_rd_due)
    );

    // ---------------- byte mask ----------------
    logic [W-1:0] w_keep;
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_keep
            assign w_keep[gi*8 +: 8] = f_byte_keep(dfi.dfi_wrdata_mask[gi]);
        end
    endgenerate

    // ---------------- loopback FIFO ----------------
    logic [W-1:0]          r_mem [DEPTH];
    logic [C_ADDR_WIDTH:0] r_wptr, r_rptr;
    logic                  w_empty, w_full, w_pop, w_push;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[C_ADDR_WIDTH] != r_rptr[C_ADDR_WIDTH]) &&
                     (r_wptr[C_ADDR_WIDTH-1:0] == r_rptr[C_ADDR_WIDTH-1:0]);
    assign w_pop   = w_rd_due && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = w_push_req && (!w_full || w_pop);

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge core_clk) begin
        if (w_push) begin
            r_mem[r_wptr[C_ADDR_WIDTH-1:0]] <= dfi.dfi_wrdata & w_keep;
        end
    end

    // ---------------- control / read register ----------------
    logic [W-1:0]             r_rddata;
    logic                     r_valid;
    logic [C_CNT_WIDTH-1:0]   r_wr_count, r_rd_count;
    logic                     r_err_overflow, r_err_underflow, r_err_phase;

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_rddata        <= '0;
            r_valid         <= 1'b0;
            r_wr_count      <= '0;
            r_rd_count      <= '0;
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
            r_err_phase     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr     <= r_wptr + 1'b1;
                r_wr_count <= r_wr_count + 1'b1;
            end
            if (w_push_req && !w_push) begin
                r_err_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            // A return due on an empty FIFO is still signalled valid, with zero data.
            if (w_rd_due) begin
                r_rd_count <= r_rd_count + 1'b1;
                if (w_empty) begin
                    r_err_underflow <= 1'b1;
                end
            end
            r_valid  <= w_rd_due;
            r_rddata <= w_pop ? r_mem[r_rptr[C_ADDR_WIDTH-1:0]] : '0;
            if (w_phase_bad) begin
                r_err_phase <= 1'b1;
            end
        end
    end

    assign dfi.dfi_rddata       = r_rddata;
    assign dfi.dfi_rddata_valid = {C_DFI_FREQ_RATIO{r_valid}};
    assign wr_count             = r_wr_count;
    assign rd_count             = r_rd_count;
    assign err_overflow         = r_err_overflow;
    assign err_underflow        = r_err_underflow;
    assign err_phase            = r_err_phase;
endmodule

// File: tb/tb_dfi_phy_datapath.sv
module tb_dfi_phy_datapath;
    localparam int R    = 4;
    localparam int DW   = 32;
    localparam int W    = R * DW;
    localparam int NB   = W / 8;
    localparam int AW   = 6;
    localparam int WRL  = 2;
    localparam int RDL  = 3;
    localparam int MAXC = 80;

    logic        core_clk = 1'b0;
    logic        core_rst = 1'b1;
    logic [15:0] wr_count, rd_count;
    logic        err_overflow, err_underflow, err_phase;

    int n_vec = 0;
    int n_err = 0;

    // stimulus schedule (index = cycle the enable is driven) and captured outputs
    logic [R-1:0]  s_wr_en   [MAXC];
    logic [W-1:0]  s_wr_data [MAXC];
    logic [NB-1:0] s_mask    [MAXC];
    logic [R-1:0]  s_rd_en   [MAXC];
    logic [R-1:0]  c_valid   [MAXC];
    logic [W-1:0]  c_data    [MAXC];

    dfi_phy_datapath_if #(.C_DFI_FREQ_RATIO(R), .C_DFI_DATA_WIDTH(DW)) dfi_bus ();

    dfi_phy_datapath #(
        .C_DFI_FREQ_RATIO (R),
        .C_DFI_DATA_WIDTH (DW),
        .C_ADDR_WIDTH     (AW),
        .C_TPHY_WRLAT     (4'(WRL)),
        .C_TPHY_RDLAT     (4'(RDL))
    ) dut (
        .core_clk      (core_clk),
        .core_rst      (core_rst),
        .dfi           (dfi_bus),
        .wr_count      (wr_count),
        .rd_count      (rd_count),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .err_phase     (err_phase)
    );

    always #5 core_clk = ~core_clk;

    task automatic drive_idle();
        dfi_bus.dfi_wrdata_en   = '0;
        dfi_bus.dfi_wrdata      = '0;
        dfi_bus.dfi_wrdata_mask = '0;
        dfi_bus.dfi_rddata_en   = '0;
    endtask

    task automatic clear_sched();
        for (int i = 0; i < MAXC; i++) begin
            s_wr_en[i]   = '0;
            s_wr_data[i] = '0;
            s_mask[i]    = '0;
            s_rd_en[i]   = '0;
            c_valid[i]   = '0;
            c_data[i]    = '0;
        end
    endtask

    // Drives the schedule one cycle per negedge; write data/mask follow their
    // enable by WRL cycles. Outputs are captured before each cycle's drive, so a
    // read enable driven at cycle j shows up in c_valid[j+RDL].
    task automatic run_seq(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge core_clk);
            c_valid[c] = dfi_bus.dfi_rddata_valid;
            c_data[c]  = dfi_bus.dfi_rddata;
            dfi_bus.dfi_wrdata_en = s_wr_en[c];
            dfi_bus.dfi_rddata_en = s_rd_en[c];
            if (c >= WRL && s_wr_en[c-WRL] != '0) begin
                dfi_bus.dfi_wrdata      = s_wr_data[c-WRL];
                dfi_bus.dfi_wrdata_mask = s_mask[c-WRL];
            end else begin
                dfi_bus.dfi_wrdata      = '0;
                dfi_bus.dfi_wrdata_mask = '0;
            end
        end
        @(negedge core_clk);
        drive_idle();
    endtask

    task automatic pulse_reset();
        @(negedge core_clk);
        core_rst = 1'b1;
        drive_idle();
        repeat (3) @(negedge core_clk);
        core_rst = 1'b0;
    endtask

    task automatic test_reset();
        core_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge core_clk);
            dfi_bus.dfi_wrdata_en   = (i == 1) ? R'(4'b0011) : '1;
            dfi_bus.dfi_rddata_en   = (i == 2) ? R'(4'b0110) : '1;
            dfi_bus.dfi_wrdata      = {(W/32){32'hDEAD_BEEF}};
            dfi_bus.dfi_wrdata_mask = '0;
        end
        @(negedge core_clk);
        n_vec++; if (dfi_bus.dfi_rddata_valid !== '0) begin n_err++; $display("FAIL reset_valid: got %h want 0", dfi_bus.dfi_rddata_valid); end
        n_vec++; if (dfi_bus.dfi_rddata !== '0) begin n_err++; $display("FAIL reset_rddata: got %h want 0", dfi_bus.dfi_rddata); end
        n_vec++; if (wr_count !== 16'd0) begin n_err++; $display("FAIL reset_wr_count: got %0d want 0", wr_count); end
        n_vec++; if (rd_count !== 16'd0) begin n_err++; $display("FAIL reset_rd_count: got %0d want 0", rd_count); end
        n_vec++; if (err_overflow !== 1'b0) begin n_err++; $display("FAIL reset_err_overflow: got %b want 0", err_overflow); end
        n_vec++; if (err_underflow !== 1'b0) begin n_err++; $display("FAIL reset_err_underflow: got %b want 0", err_underflow); end
        n_vec++; if (err_phase !== 1'b0) begin n_err++; $display("FAIL reset_err_phase: got %b want 0", err_phase); end
        core_rst = 1'b0;
        drive_idle();
        for (int i = 0; i < 6; i++) begin
            @(negedge core_clk);
            n_vec++; if (dfi_bus.dfi_rddata_valid !== '0) begin n_err++; $display("FAIL post_reset_valid[%0d]: got %h want 0", i, dfi_bus.dfi_rddata_valid); end
        end
        n_vec++; if (wr_count !== 16'd0 || rd_count !== 16'd0) begin n_err++; $display("FAIL post_reset_counts: got wr=%0d rd=%0d want 0/0", wr_count, rd_count); end
        $display("test_reset done");
    endtask

    task automatic test_loopback();
        logic [R-1:0] ev;
        logic [W-1:0] ed;
        clear_sched();
        for (int c = 0; c < 4; c++) begin
            s_wr_en[c]   = '1;
            s_wr_data[c] = W'(c + 1);
        end
        run_seq(10);
        n_vec++; if (wr_count !== 16'd4) begin n_err++; $display("FAIL loop_wr_count: got %0d want 4", wr_count); end
        clear_sched();
        for (int c = 0; c < 4; c++) s_rd_en[c] = '1;
        run_seq(10);
        for (int c = 0; c < 10; c++) begin
            ev = (c >= 3 && c < 7) ? '1 : '0;
            ed = (c >= 3 && c < 7) ? W'(c - 2) : '0;
            n_vec++; if (c_valid[c] !== ev || c_data[c] !== ed) begin n_err++; $display("FAIL loop_read[%0d]: got v=%h d=%h want v=%h d=%h", c, c_valid[c], c_data[c], ev, ed); end
        end
        n_vec++; if (rd_count !== 16'd4) begin n_err++; $display("FAIL loop_rd_count: got %0d want 4", rd_count); end
        n_vec++; if ({err_overflow, err_underflow, err_phase} !== 3'b000) begin n_err++; $display("FAIL loop_errs: got %b want 000", {err_overflow, err_underflow, err_phase}); end
        $display("test_loopback done: wr=%0d rd=%0d", wr_count, rd_count);
    endtask

    task automatic test_mask();
        logic [W-1:0] exp0, exp1;
        exp0 = {{(W-8){1'b1}}, 8'h00};
        exp1 = 128'h00110033_44556677_8899AABB_CC00EE00;
        clear_sched();
        s_wr_en[0] = '1; s_wr_data[0] = '1; s_mask[0] = 16'h0001;
        s_wr_en[1] = '1; s_wr_data[1] = 128'h00112233_44556677_8899AABB_CCDDEEFF; s_mask[1] = 16'hA005;
        run_seq(8);
        clear_sched();
        s_rd_en[0] = '1;
        s_rd_en[1] = '1;
        run_seq(8);
        n_vec++; if (c_valid[3] !== '1 || c_data[3] !== exp0) begin n_err++; $display("FAIL mask_byte0: got v=%h d=%h want v=f d=%h", c_valid[3], c_data[3], exp0); end
        n_vec++; if (c_valid[4] !== '1 || c_data[4] !== exp1) begin n_err++; $display("FAIL mask_multi: got v=%h d=%h want v=f d=%h", c_valid[4], c_data[4], exp1); end
        $display("test_mask done");
    endtask

    task automatic test_overflow();
        logic [R-1:0] ev;
        logic [W-1:0] ed;
        pulse_reset();
        clear_sched();
        for (int c = 0; c < 65; c++) begin
            s_wr_en[c]   = '1;
            s_wr_data[c] = W'(c + 1);
        end
        run_seq(70);
        n_vec++; if (wr_count !== 16'd64) begin n_err++; $display("FAIL ovf_wr_count: got %0d want 64", wr_count); end
        n_vec++; if (err_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", err_overflow); end
        clear_sched();
        for (int c = 0; c < 64; c++) s_rd_en[c] = '1;
        run_seq(70);
        for (int c = 0; c < 70; c++) begin
            ev = (c >= 3 && c < 67) ? '1 : '0;
            ed = (c >= 3 && c < 67) ? W'(c - 2) : '0;
            n_vec++; if (c_valid[c] !== ev || c_data[c] !== ed) begin n_err++; $display("FAIL ovf_read[%0d]: got v=%h d=%h want v=%h d=%h", c, c_valid[c], c_data[c], ev, ed); end
        end
        n_vec++; if (rd_count !== 16'd64 || err_underflow !== 1'b0) begin n_err++; $display("FAIL ovf_drain: got rd=%0d unf=%b want 64/0", rd_count, err_underflow); end
        $display("test_overflow done: wr=%0d rd=%0d", wr_count, rd_count);
    endtask

    task automatic test_underflow_simul();
        logic [W-1:0] ed;
        pulse_reset();
        clear_sched();
        s_rd_en[0] = '1;
        run_seq(6);
        n_vec++; if (c_valid[3] !== '1 || c_data[3] !== '0) begin n_err++; $display("FAIL unf_read: got v=%h d=%h want v=f d=0", c_valid[3], c_data[3]); end
        n_vec++; if (err_underflow !== 1'b1 || rd_count !== 16'd1) begin n_err++; $display("FAIL unf_flag: got unf=%b rd=%0d want 1/1", err_underflow, rd_count); end
        // fill to full
        clear_sched();
        for (int c = 0; c < 64; c++) begin
            s_wr_en[c]   = '1;
            s_wr_data[c] = W'(32'h100 + c);
        end
        run_seq(70);
        n_vec++; if (wr_count !== 16'd64 || err_overflow !== 1'b0) begin n_err++; $display("FAIL fill: got wr=%0d ovf=%b want 64/0", wr_count, err_overflow); end
        // full: push and pop land on the same edge
        clear_sched();
        s_wr_en[0] = '1; s_wr_data[0] = W'(32'h777);
        s_rd_en[0] = '1;
        run_seq(6);
        n_vec++; if (c_valid[3] !== '1 || c_data[3] !== W'(32'h100)) begin n_err++; $display("FAIL full_simul_read: got v=%h d=%h want v=f d=100", c_valid[3], c_data[3]); end
        n_vec++; if (err_overflow !== 1'b0 || wr_count !== 16'd65) begin n_err++; $display("FAIL full_simul_push: got ovf=%b wr=%0d want 0/65", err_overflow, wr_count); end
        // drain: 64 beats remain, ending with the simultaneously pushed one
        clear_sched();
        for (int c = 0; c < 64; c++) s_rd_en[c] = '1;
        run_seq(70);
        for (int c = 0; c < 64; c++) begin
            ed = (c < 63) ? W'(32'h101 + c) : W'(32'h777);
            n_vec++; if (c_valid[c+3] !== '1 || c_data[c+3] !== ed) begin n_err++; $display("FAIL drain[%0d]: got v=%h d=%h want v=f d=%h", c, c_valid[c+3], c_data[c+3], ed); end
        end
        // empty: return underflows while the push stores
        clear_sched();
        s_wr_en[0] = '1; s_wr_data[0] = W'(32'h888);
        s_rd_en[0] = '1;
        s_rd_en[1] = '1;
        run_seq(7);
        n_vec++; if (c_valid[3] !== '1 || c_data[3] !== '0) begin n_err++; $display("FAIL empty_simul_read: got v=%h d=%h want v=f d=0", c_valid[3], c_data[3]); end
        n_vec++; if (c_valid[4] !== '1 || c_data[4] !== W'(32'h888)) begin n_err++; $display("FAIL empty_simul_stored: got v=%h d=%h want v=f d=888", c_valid[4], c_data[4]); end
        n_vec++; if (rd_count !== 16'd68 || wr_count !== 16'd66) begin n_err++; $display("FAIL simul_counts: got rd=%0d wr=%0d want 68/66", rd_count, wr_count); end
        $display("test_underflow_simul done: wr=%0d rd=%0d", wr_count, rd_count);
    endtask

    task automatic test_partial_phase();
        pulse_reset();
        @(negedge core_clk);
        n_vec++; if (err_phase !== 1'b0) begin n_err++; $display("FAIL phase_clear: got %b want 0", err_phase); end
        clear_sched();
        s_wr_en[0] = R'(4'b0011); s_wr_data[0] = W'(32'h55);
        run_seq(6);
        n_vec++; if (err_phase !== 1'b1 || wr_count !== 16'd1) begin n_err++; $display("FAIL phase_write: got phase=%b wr=%0d want 1/1", err_phase, wr_count); end
        clear_sched();
        s_rd_en[0] = '1;
        run_seq(6);
        n_vec++; if (c_valid[3] !== '1 || c_data[3] !== W'(32'h55)) begin n_err++; $display("FAIL phase_read: got v=%h d=%h want v=f d=55", c_valid[3], c_data[3]); end
        $display("test_partial_phase done");
    endtask

    task automatic test_reset_mid_read();
        logic [R-1:0] ev;
        pulse_reset();
        clear_sched();
        s_wr_en[0] = '1; s_wr_data[0] = W'(32'hA);
        s_wr_en[1] = '1; s_wr_data[1] = W'(32'hB);
        run_seq(6);
        dfi_bus.dfi_rddata_en = '1;
        @(negedge core_clk);
        dfi_bus.dfi_rddata_en = '1;
        @(negedge core_clk);
        dfi_bus.dfi_rddata_en = '0;
        core_rst = 1'b1;
        @(negedge core_clk);
        n_vec++; if (dfi_bus.dfi_rddata_valid !== '0) begin n_err++; $display("FAIL midrst_hold_valid: got %h want 0", dfi_bus.dfi_rddata_valid); end
        @(negedge core_clk);
        core_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge core_clk);
            n_vec++; if (dfi_bus.dfi_rddata_valid !== '0 || dfi_bus.dfi_rddata !== '0) begin n_err++; $display("FAIL midrst_stray[%0d]: got v=%h d=%h want 0/0", i, dfi_bus.dfi_rddata_valid, dfi_bus.dfi_rddata); end
        end
        n_vec++; if (rd_count !== 16'd0 || wr_count !== 16'd0 || err_underflow !== 1'b0) begin n_err++; $display("FAIL midrst_state: got rd=%0d wr=%0d unf=%b want 0/0/0", rd_count, wr_count, err_underflow); end
        clear_sched();
        s_rd_en[2] = '1;
        run_seq(8);
        for (int c = 0; c < 8; c++) begin
            ev = (c == 5) ? '1 : '0;
            n_vec++; if (c_valid[c] !== ev || c_data[c] !== '0) begin n_err++; $display("FAIL post_rst_read[%0d]: got v=%h d=%h want v=%h d=0", c, c_valid[c], c_data[c], ev); end
        end
        n_vec++; if (err_underflow !== 1'b1 || rd_count !== 16'd1) begin n_err++; $display("FAIL post_rst_unf: got unf=%b rd=%0d want 1/1", err_underflow, rd_count); end
        $display("test_reset_mid_read done");
    endtask

    initial begin
        drive_idle();
        clear_sched();
        test_reset();
        test_loopback();
        test_mask();
        test_overflow();
        test_underflow_simul();
        test_partial_phase();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
